// File: rtl/apb_pkg.sv
// Shared APB types: bus parameters, command/response payloads and the bridge
// FSM state encoding. The payload structs are sized from the default
// apb_parameter widths.
package apb_pkg;

  typedef struct packed {
    int unsigned addr_width;
    int unsigned data_width;
  } apb_parameter_t;

  localparam apb_parameter_t apb_parameter = '{addr_width: 32, data_width: 32};

  localparam int unsigned APB_ADDR_WIDTH = apb_parameter.addr_width;
  localparam int unsigned APB_DATA_WIDTH = apb_parameter.data_width;
  localparam int unsigned APB_STRB_WIDTH = APB_DATA_WIDTH / 8;

  typedef struct packed {
    logic                      write;
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_DATA_WIDTH-1:0] wdata;
    logic [APB_STRB_WIDTH-1:0] strb;
    logic                      prot;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      err;
    logic                      timeout;
  } apb_rsp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_mst_state_e;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO for the APB bridge.
// Ports: clk/reset (sync, active-high); push/wdata write side; pop/head_c
// read side (head_c is the current head, valid when !empty_c); empty_c is
// decoded from the occupancy register; ready is a registered not-full flag.
module apb_cmd_fifo
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  apb_cmd_t wdata,
  input  logic     pop,
  output apb_cmd_t head_c,
  output logic     empty_c,
  output logic     ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  apb_cmd_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  // A pop never frees space for a same-cycle push: ready is last cycle's view.
  assign do_push = push && ready;
  assign do_pop  = pop && !empty_c;
  assign empty_c = (count_q == '0);
  assign head_c  = mem[rd_ptr_q];

  // Occupancy update; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready    <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      ready   <= (count_d != CNT_W'(DEPTH));
    end
  end

  // Storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to APB4 master bridge with one response per
// command and a pready timeout.
// Ports: clk/reset (sync, active-high); cmd_* command stream in; rsp_*
// response stream out; p* APB4 master signals. All outputs are registered.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = apb_parameter.addr_width,
  parameter int unsigned DATA_WIDTH     = apb_parameter.data_width,
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic                    cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    pprot,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned TCNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TCNT_LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  apb_cmd_t cmd_in;
  apb_cmd_t head_c;
  logic     fifo_empty_c;
  logic     fifo_pop;

  apb_mst_state_e          state_q, state_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic                    pprot_q, pprot_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
  logic                    rsp_valid_q, rsp_valid_d;
  apb_rsp_t                rsp_q, rsp_d;
  logic [TCNT_W-1:0]       tcnt_q, tcnt_d;

  // Pack the incoming command into the FIFO payload.
  always_comb begin
    cmd_in.write = cmd_write;
    cmd_in.addr  = APB_ADDR_WIDTH'(cmd_addr);
    cmd_in.wdata = APB_DATA_WIDTH'(cmd_wdata);
    cmd_in.strb  = APB_STRB_WIDTH'(cmd_strb);
    cmd_in.prot  = cmd_prot;
  end

  apb_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (cmd_valid),
    .wdata   (cmd_in),
    .pop     (fifo_pop),
    .head_c  (head_c),
    .empty_c (fifo_empty_c),
    .ready   (cmd_ready)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pprot_d     = pprot_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    tcnt_d      = tcnt_q;
    fifo_pop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_c) begin
          fifo_pop = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        tcnt_d    = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          rsp_d.rdata   = pwrite_q ? '0 : APB_DATA_WIDTH'(prdata);
          rsp_d.err     = pslverr;
          rsp_d.timeout = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (tcnt_q == TCNT_W'(TCNT_LAST))) begin
          rsp_d.rdata   = '0;
          rsp_d.err     = 1'b1;
          rsp_d.timeout = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty_c) begin
            fifo_pop = 1'b1;
            state_d  = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every pop starts a SETUP phase from the FIFO head; reads never strobe.
    if (fifo_pop) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = head_c.write;
      pprot_d   = head_c.prot;
      paddr_d   = ADDR_WIDTH'(head_c.addr);
      pwdata_d  = DATA_WIDTH'(head_c.wdata);
      pstrb_d   = head_c.write ? STRB_WIDTH'(head_c.strb) : '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pprot_q     <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pprot_q     <= pprot_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign pprot       = pprot_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = DATA_WIDTH'(rsp_q.rdata);
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus a
// randomized phase, against a transaction-level slave/response model.
module tb_apb_master_bridge;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write, cmd_prot;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic          pprot, psel, penable, pwrite, pready, pslverr;
  logic [DW-1:0] pwdata, prdata;
  logic [SW-1:0] pstrb;

  apb_master_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  // One command plus how the slave will answer it.
  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic          prot;
    int unsigned   wait_n;
    logic          err;
    logic [DW-1:0] rdata;
  } plan_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          timeout;
  } exp_rsp_t;

  plan_t    plan_q[$];
  exp_rsp_t exp_q[$];
  int       checks = 0;
  int       errors = 0;
  bit       rand_on;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic plan_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                               input logic [SW-1:0] s, input int unsigned wt, input logic er,
                               input logic [DW-1:0] rd);
    plan_t p;
    p.write = w; p.addr = a; p.wdata = wd; p.strb = s; p.prot = 1'($urandom_range(0, 1));
    p.wait_n = wt; p.err = er; p.rdata = rd;
    return p;
  endfunction

  // Offer a command (caller is at a negedge); returns at the negedge after the handshake.
  task automatic push(input plan_t p);
    int unsigned n = 0;
    exp_rsp_t    e;
    cmd_valid = 1'b1; cmd_write = p.write; cmd_addr = p.addr; cmd_wdata = p.wdata;
    cmd_strb = p.strb; cmd_prot = p.prot;
    while (!cmd_ready) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        check("push_stall", cmd_ready, 1);
        cmd_valid = 1'b0;
        return;
      end
    end
    plan_q.push_back(p);
    e.timeout = (p.wait_n >= TMO);
    e.err     = e.timeout || p.err;
    e.rdata   = (e.timeout || p.write) ? '0 : p.rdata;
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int unsigned limit);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  // APB slave model: answers each transfer from its plan and checks the bus.
  initial begin : slave
    plan_t         cur;
    logic [AW-1:0] s_addr;
    logic [37:0]   s_rest;
    int unsigned   acc = 0;
    bit            in_acc = 0;
    bit            have = 0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    forever begin
      @(negedge clk);
      pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
      if (reset) begin
        in_acc = 0; have = 0;
      end else if (psel && !penable) begin
        check("setup_expected", plan_q.size() != 0, 1);
        have = 0;
        if (plan_q.size() != 0) begin
          cur = plan_q.pop_front();
          have = 1;
          check("setup_paddr", paddr, cur.addr);
          check("setup_pwrite", pwrite, cur.write);
          check("setup_pwdata", pwdata, cur.wdata);
          check("setup_pstrb", pstrb, cur.write ? cur.strb : '0);
          check("setup_pprot", pprot, cur.prot);
        end
        s_addr = paddr; s_rest = {pwdata, pstrb, pwrite, pprot};
        acc = 0; in_acc = 0;
      end else if (psel && penable) begin
        check("access_addr_stable", paddr, s_addr);
        check("access_ctl_stable", {pwdata, pstrb, pwrite, pprot}, s_rest);
        in_acc = 1;
        if (have && acc == cur.wait_n) begin
          pready = 1'b1; prdata = cur.rdata; pslverr = cur.err;
        end
        acc++;
      end else if (in_acc) begin
        in_acc = 0;
        if (have) check("access_cycles", acc, (cur.wait_n >= TMO) ? TMO : cur.wait_n + 1);
      end
    end
  end

  // Response monitor: ordering, contents, stability while stalled, single outstanding.
  initial begin : rsp_mon
    logic [33:0] held;
    bit          hold = 0;
    exp_rsp_t    e;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        hold = 0;
      end else if (rsp_valid) begin
        check("one_outstanding", psel, 0);
        if (hold) check("rsp_stable", {rsp_rdata, rsp_err, rsp_timeout}, held);
        if (rsp_ready) begin
          check("rsp_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", rsp_err, e.err);
            check("rsp_timeout", rsp_timeout, e.timeout);
          end
          hold = 0;
        end else begin
          held = {rsp_rdata, rsp_err, rsp_timeout};
          hold = 1;
        end
      end else begin
        hold = 0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int unsigned n;
    int unsigned wt;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_bits", {rsp_rdata, rsp_err, rsp_timeout}, 0);
    check("rst_apb_bus", {paddr, pwdata, pstrb, pwrite, pprot}, 0);
    check("rst_cmd_ready", cmd_ready, 1);

    // Single write: latency of SETUP, ACCESS and response.
    push(mk(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0));
    check("t1_idle_after_push", psel, 0);
    @(negedge clk);
    check("t1_setup_psel", psel, 1);
    check("t1_setup_penable", penable, 0);
    @(negedge clk);
    check("t1_access", {psel, penable}, 2'b11);
    @(negedge clk);
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_psel_dropped", psel, 0);
    check("t1_rsp_err", rsp_err, 0);
    check("t1_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    drain(50);

    // Read with three wait states.
    push(mk(1'b0, 32'h20, 32'h5555AAAA, 4'hF, 3, 1'b0, 32'hCAFEF00D));
    drain(50);

    // Six commands with the response stalled: one in flight plus four queued fills the FIFO.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(mk(1'(i & 1), 32'h100 + 32'(i * 4), $urandom, 4'(i + 1), 0, 1'b0, $urandom));
    check("t3_full", cmd_ready, 0);
    check("t3_first_rsp", rsp_valid, 1);
    fork
      push(mk(1'b0, 32'h200, $urandom, 4'h3, 0, 1'b0, 32'h600D0006));
      begin
        repeat (5) begin
          @(negedge clk);
          check("t3_no_second_psel", psel, 0);
        end
        rsp_ready = 1'b1;
      end
    join
    drain(200);

    // pready never comes: timeout after TMO ACCESS cycles.
    push(mk(1'b0, 32'h40, $urandom, 4'hF, 1000, 1'b0, 32'h12345678));
    drain(100);

    // Slave error on a write.
    push(mk(1'b1, 32'h30, 32'h0BADF00D, 4'hC, 0, 1'b1, 32'h0));
    drain(50);

    // Reset during ACCESS with two commands queued.
    for (int i = 0; i < 3; i++)
      push(mk(1'b1, 32'h70 + 32'(i), $urandom, 4'hF, 10, 1'b0, 32'h0));
    n = 0;
    while (!penable && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_in_access", penable, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_psel", psel, 0);
    check("t6_penable", penable, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    plan_q.delete();
    exp_q.delete();
    repeat (4) @(negedge clk);
    check("t6_no_rsp", rsp_valid, 0);
    check("t6_no_psel", psel, 0);
    push(mk(1'b0, 32'h50, $urandom, 4'hF, 1, 1'b0, 32'hA5A5_1234));
    drain(50);

    // Randomized traffic with random response back-pressure.
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          wt = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 3);
          push(mk(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                  wt, 1'($urandom_range(0, 1)), $urandom));
        end
        drain(3000);
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(negedge clk);
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
